// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU arbiter slice.
// Holds the arbiter state enum, status flag bit positions and the
// opcode encodings the arbiter forwards unchanged to the shared ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Status flag bit positions as produced by the ALU
  localparam int STATUS_ZERO  = 0;
  localparam int STATUS_NEG   = 1;
  localparam int STATUS_CARRY = 2;
  localparam int STATUS_OVF   = 3;

  // Opcodes understood by the shared ALU; the arbiter only passes them through
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_GT  = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_EQ  = 3'd6;
  localparam logic [2:0] OP_LT  = 3'd7;

  // One-hot vector for a 2-way requester index
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant.
// A lone requester always wins; on a tie the requester that was not
// served last wins. Grant is one-hot, or zero when nobody requests.
module rr_arbiter_2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // Pick the winner from the current requests and the last-served index
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: schedules two requesters onto one combinational ALU.
// IDLE arbitrates and accepts one request, EXEC lets the ALU settle on
// the registered operands and captures its outputs, RESP holds the
// response until the owning requester consumes it.
// Optional feature: define ALU_ARB_STATUS_ACC_EN to add a sticky OR
// accumulator of delivered status flags (i_status_clr / o_status_acc).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int M   = 8,
  parameter int K   = 8,
  parameter int OPW = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  logic [2*OPW-1:0] i_req_op,
  input  logic [2*M-1:0]   i_req_A,
  input  logic [2*M-1:0]   i_req_B,
  output logic [1:0]       o_rsp_valid,
  input  logic [1:0]       i_rsp_ready,
  output logic [K-1:0]     o_rsp_result,
  output logic [3:0]       o_rsp_status,
  output logic [OPW-1:0]   o_alu_op,
  output logic [M-1:0]     o_alu_A,
  output logic [M-1:0]     o_alu_B,
  input  logic [K-1:0]     i_alu_result,
  input  logic [3:0]       i_alu_status,
`ifdef ALU_ARB_STATUS_ACC_EN
  input  logic             i_status_clr,
  output logic [3:0]       o_status_acc,
`endif
  output logic             o_busy
);

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_q, last_d;
  logic [OPW-1:0] aluOp_q, aluOp_d;
  logic [M-1:0]   aluA_q, aluA_d;
  logic [M-1:0]   aluB_q, aluB_d;
  logic [K-1:0]   rspResult_q, rspResult_d;
  logic [3:0]     rspStatus_q, rspStatus_d;

  logic [1:0]     grant;
  logic [1:0]     reqReady;
  logic [1:0]     rspValid;
  logic           reqFire;
  logic           rspFire;
  logic           winIdx;

  rr_arbiter_2 u_rr (
    .req_i   (i_req_valid),
    .last_i  (last_q),
    .grant_o (grant)
  );

  assign winIdx = grant[1];

  // Next-state, handshake and datapath-capture decisions for the scheduler
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    aluOp_d     = aluOp_q;
    aluA_d      = aluA_q;
    aluB_d      = aluB_q;
    rspResult_d = rspResult_q;
    rspStatus_d = rspStatus_q;
    reqReady    = 2'b00;
    rspValid    = 2'b00;
    reqFire     = 1'b0;
    rspFire     = 1'b0;

    case (state_q)
      IDLE: begin
        reqReady = grant;
        reqFire  = |(i_req_valid & grant);
        if (reqFire) begin
          owner_d = winIdx;
          aluOp_d = winIdx ? i_req_op[2*OPW-1:OPW] : i_req_op[OPW-1:0];
          aluA_d  = winIdx ? i_req_A[2*M-1:M]      : i_req_A[M-1:0];
          aluB_d  = winIdx ? i_req_B[2*M-1:M]      : i_req_B[M-1:0];
          state_d = EXEC;
        end
      end
      EXEC: begin
        rspResult_d = i_alu_result;
        rspStatus_d = i_alu_status;
        state_d     = RESP;
      end
      RESP: begin
        rspValid = onehot2(owner_q);
        rspFire  = i_rsp_ready[owner_q];
        if (rspFire) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, ownership, ALU drive and response registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      aluOp_q     <= '0;
      aluA_q      <= '0;
      aluB_q      <= '0;
      rspResult_q <= '0;
      rspStatus_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      aluOp_q     <= aluOp_d;
      aluA_q      <= aluA_d;
      aluB_q      <= aluB_d;
      rspResult_q <= rspResult_d;
      rspStatus_q <= rspStatus_d;
    end
  end

`ifdef ALU_ARB_STATUS_ACC_EN
  logic [3:0] statusAcc_q, statusAcc_d;

  // Sticky OR of every delivered status; a clear and a delivery in the same cycle keep the new status
  always_comb begin
    statusAcc_d = (i_status_clr ? 4'b0000 : statusAcc_q) |
                  (rspFire ? rspStatus_q : 4'b0000);
  end

  // Accumulator register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      statusAcc_q <= 4'b0000;
    end else begin
      statusAcc_q <= statusAcc_d;
    end
  end

  assign o_status_acc = statusAcc_q;
`endif

  assign o_req_ready  = reqReady;
  assign o_rsp_valid  = rspValid;
  assign o_rsp_result = rspResult_q;
  assign o_rsp_status = rspStatus_q;
  assign o_alu_op     = aluOp_q;
  assign o_alu_A      = aluA_q;
  assign o_alu_B      = aluB_q;
  assign o_busy       = (state_q != IDLE);

endmodule
